// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS data-memory load/store path.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_RD   = 2'd1,
    LSU_WR   = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_e;

  localparam int unsigned LSU_IDX_W = 8;

  // Reserved size or an address not naturally aligned for the access size.
  function automatic logic lsu_bad_req(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == SZ_RSVD) ||
           ((size == SZ_HALF) && addr_lo[0]) ||
           ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: sub-word load extraction/extension and
// read-modify-write merge of sub-word store data into the read word.
module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_store
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    o_load  = i_rdata;
    o_store = i_rdata;
    case (i_size)
      SZ_BYTE: begin
        o_load = {{24{i_signed & w_byte[7]}}, w_byte};
        o_store[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_HALF: begin
        o_load = {{16{i_signed & w_half[15]}}, w_half};
        o_store[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
      end
      default: begin
        o_load  = i_rdata;
        o_store = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store controller for a level-sensitive word memory with RMW for SB/SH.
// Define LSU_STATS_EN to add saturating load/store/error counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// LSU_IDLE | ready for a request; latches it and checks alignment
// LSU_RD   | MemRead held MEM_LAT cycles (load, or first half of RMW)
// LSU_WR   | MemWrite held MEM_LAT cycles with a stable write word
// LSU_RESP | response presented until resp_ready
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned IDX_W   = LSU_IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Mem_Address,
  output logic [31:0] Mem_Write_Data,
  input  logic [31:0] Mem_Read_Data
`ifdef LSU_STATS_EN
  ,
  output logic [15:0] stat_loads,
  output logic [15:0] stat_stores,
  output logic [15:0] stat_errs
`endif
);

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  lsu_state_e       r_state, w_next_state;
  logic [3:0]       r_lat_cnt;
  logic             r_write, r_signed, r_err;
  logic [1:0]       r_size, r_addr_lo;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_wdata, r_mem_wdata, r_rdata;
  logic [31:0]      w_load_val, w_store_word;
  logic             w_req_bad;
  logic             w_unused_addr;

  assign w_req_bad     = lsu_bad_req(req_size, req_addr[1:0]);
  assign w_unused_addr = ^req_addr[31:IDX_W+2];

  lsu_lane_align u_align (
    .i_addr_lo (r_addr_lo),
    .i_size    (r_size),
    .i_signed  (r_signed),
    .i_rdata   (Mem_Read_Data),
    .i_wdata   (r_wdata),
    .o_load    (w_load_val),
    .o_store   (w_store_word)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= LSU_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    case (r_state)
      LSU_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_bad)                             w_next_state = LSU_RESP;
          else if (req_write && req_size == SZ_WORD) w_next_state = LSU_WR;
          else                                       w_next_state = LSU_RD;
        end
      end
      LSU_RD: begin
        MemRead = 1'b1;
        if (r_lat_cnt == 4'd0) w_next_state = r_write ? LSU_WR : LSU_RESP;
      end
      LSU_WR: begin
        MemWrite = 1'b1;
        if (r_lat_cnt == 4'd0) w_next_state = LSU_RESP;
      end
      LSU_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next_state = LSU_IDLE;
      end
      default: w_next_state = LSU_IDLE;
    endcase
    // Reset is synchronous, so mask handshake and strobes while it is held.
    if (rst) begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lat_cnt   <= 4'd0;
      r_write     <= 1'b0;
      r_signed    <= 1'b0;
      r_err       <= 1'b0;
      r_size      <= SZ_BYTE;
      r_addr_lo   <= 2'b00;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (req_valid) begin
            r_lat_cnt   <= LAT_INIT;
            r_write     <= req_write;
            r_signed    <= req_signed;
            r_size      <= req_size;
            r_addr_lo   <= req_addr[1:0];
            r_idx       <= req_addr[IDX_W+1:2];
            r_wdata     <= req_wdata;
            r_err       <= w_req_bad;
            r_rdata     <= '0;
            r_mem_wdata <= (req_write && req_size == SZ_WORD) ? req_wdata : '0;
          end
        end
        LSU_RD: begin
          if (r_lat_cnt == 4'd0) begin
            if (r_write) begin
              r_mem_wdata <= w_store_word;
              r_lat_cnt   <= LAT_INIT;
            end else begin
              r_rdata <= w_load_val;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
          end
        end
        LSU_WR: begin
          if (r_lat_cnt != 4'd0) r_lat_cnt <= r_lat_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata     = rst ? '0 : r_rdata;
  assign resp_err       = rst ? 1'b0 : r_err;
  assign Mem_Address    = rst ? '0 : {{(32-IDX_W){1'b0}}, r_idx};
  assign Mem_Write_Data = rst ? '0 : r_mem_wdata;

`ifdef LSU_STATS_EN
  logic        w_resp_done;
  logic [15:0] r_stat_loads, r_stat_stores, r_stat_errs;

  assign w_resp_done = (r_state == LSU_RESP) && resp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_loads  <= '0;
      r_stat_stores <= '0;
      r_stat_errs   <= '0;
    end else if (w_resp_done) begin
      if (r_err) begin
        if (r_stat_errs != 16'hFFFF) r_stat_errs <= r_stat_errs + 16'd1;
      end else if (r_write) begin
        if (r_stat_stores != 16'hFFFF) r_stat_stores <= r_stat_stores + 16'd1;
      end else begin
        if (r_stat_loads != 16'hFFFF) r_stat_loads <= r_stat_loads + 16'd1;
      end
    end
  end

  assign stat_loads  = r_stat_loads;
  assign stat_stores = r_stat_stores;
  assign stat_errs   = r_stat_errs;
`endif

endmodule
